if_prefetch_stage: RTL and testbench

//   Parametrised RV32I instruction-fetch stage with prefetch queue. Issues in-order

---
 rtl/if_prefetch_stage_pkg.sv | 13 +
 rtl/if_prefetch_stage_if.sv | 28 ++
 rtl/if_prefetch_stage_fifo.sv | 54 +++++
 rtl/if_prefetch_stage.sv | 91 +++++++++
 tb/tb_if_prefetch_stage.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/if_prefetch_stage_pkg.sv
// Shared constants and types for the RV32I instruction-fetch stage.
package if_prefetch_stage_pkg;

  localparam int RV_XLEN = 32;
  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/if_prefetch_stage_if.sv
// Instruction-memory request/response bus plus the decode-side fetch handshake.
interface if_prefetch_stage_if
  import if_prefetch_stage_pkg::*;
#(
  parameter int XLEN = RV_XLEN
);

  logic               imem_req_valid;
  logic [XLEN-1:0]    imem_req_addr;
  logic               imem_req_ready;
  logic               imem_resp_valid;
  logic [INSTR_W-1:0] imem_resp_data;
  logic [INSTR_W-1:0] fetch_data;
  logic [XLEN-1:0]    fetch_pc;
  logic               fetch_data_valid;
  logic               fetch_ready;

  modport master (
    output imem_req_valid, imem_req_addr, fetch_data, fetch_pc, fetch_data_valid,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, fetch_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, fetch_data, fetch_pc, fetch_data_valid,
    output imem_req_ready, imem_resp_valid, imem_resp_data, fetch_ready
  );

endinterface

// File: rtl/if_prefetch_stage_fifo.sv
// Synchronous prefetch FIFO with synchronous clear; head reads as zero when empty.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  logic [WIDTH-1:0]           wr_data,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    cnt;
  logic             push_ok, pop_ok;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !clear) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/if_prefetch_stage.sv
// RV32I fetch stage: in-order imem requests, credit-limited prefetch queue, redirect flush.
module if_prefetch_stage
  import if_prefetch_stage_pkg::*;
#(
  parameter int              XLEN            = RV_XLEN,
  parameter logic [XLEN-1:0] RESET_PC        = '0,
  parameter int              FIFO_DEPTH      = 4,
  parameter int              MAX_OUTSTANDING = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                redirect_valid,
  input  logic [XLEN-1:0]     redirect_pc,
  if_prefetch_stage_if.master bus
);

  localparam int OW = $clog2(MAX_OUTSTANDING+1);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int SW = $clog2(FIFO_DEPTH+MAX_OUTSTANDING+1);
  localparam int EW = XLEN + INSTR_W;

  fetch_state_e    state;
  logic [XLEN-1:0] pc_reg, resp_pc, redirect_pc_aligned;
  logic [OW-1:0]   outstanding, outstanding_nxt, drop_cnt;
  logic [CW-1:0]   fifo_count;
  logic            fifo_full, fifo_empty;
  logic            req_valid, req_fire, resp_fire, resp_drop, push, pop;
  logic [EW-1:0]   wr_entry, rd_entry;

  assign redirect_pc_aligned = redirect_pc & ~XLEN'(3);

  // Credit rule: every request in flight has a reserved FIFO slot, so pushes never overflow.
  assign req_valid = (state == RUN) && en && !redirect_valid
                  && (outstanding < OW'(MAX_OUTSTANDING))
                  && ((SW'(fifo_count) + SW'(outstanding)) < SW'(FIFO_DEPTH));

  assign req_fire        = req_valid && bus.imem_req_ready;
  assign resp_fire       = bus.imem_resp_valid && (outstanding != '0);
  assign resp_drop       = resp_fire && (drop_cnt != '0);
  assign pop             = bus.fetch_data_valid && bus.fetch_ready && !redirect_valid;
  assign push            = resp_fire && !resp_drop && !redirect_valid && (!fifo_full || pop);
  assign outstanding_nxt = outstanding + OW'(req_fire) - OW'(resp_fire);
  assign wr_entry        = {resp_pc, bus.imem_resp_data};

  assign bus.imem_req_valid   = req_valid;
  assign bus.imem_req_addr    = pc_reg;
  assign bus.fetch_pc         = rd_entry[EW-1:INSTR_W];
  assign bus.fetch_data       = rd_entry[INSTR_W-1:0];
  assign bus.fetch_data_valid = !fifo_empty;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .clear   (redirect_valid),
    .wr_data (wr_entry),
    .rd_data (rd_entry),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= BOOT;
      pc_reg      <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      if (state == BOOT) state <= RUN;
      outstanding <= outstanding_nxt;
      // Everything still in flight after a redirect belongs to the old path and is dropped.
      if (redirect_valid) begin
        pc_reg   <= redirect_pc_aligned;
        resp_pc  <= redirect_pc_aligned;
        drop_cnt <= outstanding_nxt;
      end else begin
        if (req_fire)  pc_reg   <= pc_reg + XLEN'(PC_STEP);
        if (push)      resp_pc  <= resp_pc + XLEN'(PC_STEP);
        if (resp_drop) drop_cnt <= drop_cnt - OW'(1);
      end
    end
  end

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Randomized and directed bench for if_prefetch_stage against a queue-based fetch model.
module tb_if_prefetch_stage;

  localparam int DEPTH = 4;
  localparam int MAXO  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  if_prefetch_stage_if #(.XLEN(32)) bus();

  if_prefetch_stage #(
    .XLEN            (32),
    .RESET_PC        (32'h0),
    .FIFO_DEPTH      (DEPTH),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] pc; logic [31:0] instr; } ent_t;
  typedef struct { logic [31:0] addr; bit stale; } inf_t;

  ent_t        m_fifo[$];
  inf_t        m_infl[$];
  logic [31:0] m_pc;
  bit          m_run;

  logic [31:0] memq[$];
  logic [31:0] delivered[$];
  int          nreq;
  bit          fready, rrdy, mem_hold, rand_lat;
  int          n_chk = 0;
  int          n_fail = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] dlv(input int i);
    return (i < delivered.size()) ? delivered[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    en = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    bus.imem_req_ready = 1'b1;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data = '0;
    bus.fetch_ready = fready;
    #1;
    check_eq("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
    check_eq("rst_req_addr", 64'(bus.imem_req_addr), 64'd0);
    check_eq("rst_fetch_valid", 64'(bus.fetch_data_valid), 64'd0);
    check_eq("rst_fetch_data", 64'(bus.fetch_data), 64'd0);
    check_eq("rst_fetch_pc", 64'(bus.fetch_pc), 64'd0);
    m_fifo.delete();
    m_infl.delete();
    memq.delete();
    m_pc = '0;
    m_run = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic step(input bit r, input logic [31:0] rp);
    bit   fv, exp_rv, resp_v;
    inf_t f;
    redirect_valid = r;
    redirect_pc = rp;
    bus.imem_req_ready = rrdy;
    bus.fetch_ready = fready;
    resp_v = 1'b0;
    if (!mem_hold && memq.size() != 0 && (!rand_lat || $urandom_range(0, 1) == 1)) begin
      resp_v = 1'b1;
      bus.imem_resp_data = memf(memq.pop_front());
    end else begin
      bus.imem_resp_data = $urandom;
    end
    bus.imem_resp_valid = resp_v;
    #1;
    exp_rv = m_run && en && !r && (m_infl.size() < MAXO) && ((m_fifo.size() + m_infl.size()) < DEPTH);
    fv = (m_fifo.size() != 0);
    check_eq("req_valid", 64'(bus.imem_req_valid), 64'(exp_rv));
    check_eq("req_addr", 64'(bus.imem_req_addr), 64'(m_pc));
    check_eq("fetch_valid", 64'(bus.fetch_data_valid), 64'(fv));
    if (fv) begin
      check_eq("fetch_pc", 64'(bus.fetch_pc), 64'(m_fifo[0].pc));
      check_eq("fetch_data", 64'(bus.fetch_data), 64'(m_fifo[0].instr));
    end
    if (!r && bus.fetch_data_valid && fready) delivered.push_back(bus.fetch_pc);
    if (bus.imem_req_valid && bus.imem_req_ready) begin
      memq.push_back(bus.imem_req_addr);
      nreq++;
    end
    if (r) begin
      m_fifo.delete();
      if (resp_v && m_infl.size() != 0) void'(m_infl.pop_front());
      foreach (m_infl[i]) m_infl[i].stale = 1'b1;
      m_pc = rp & ~32'd3;
    end else begin
      if (fv && fready) void'(m_fifo.pop_front());
      if (resp_v && m_infl.size() != 0) begin
        f = m_infl.pop_front();
        if (!f.stale) m_fifo.push_back('{pc: f.addr, instr: memf(f.addr)});
      end
      if (exp_rv && rrdy) begin
        m_infl.push_back('{addr: m_pc, stale: 1'b0});
        m_pc = m_pc + 32'd4;
      end
    end
    m_run = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    fready = 1'b1;
    rrdy = 1'b1;
    mem_hold = 1'b0;
    rand_lat = 1'b0;
    nreq = 0;
    #1;

    // Reset, boot cycle, then streaming at one instruction per cycle
    do_reset();
    delivered.delete();
    step(1'b0, '0);
    check_eq("s1_req_valid", 64'(bus.imem_req_valid), 64'd1);
    check_eq("s1_req_addr", 64'(bus.imem_req_addr), 64'd0);
    repeat (11) step(1'b0, '0);
    check_eq("s2_count", 64'(delivered.size()), 64'd9);
    for (int i = 0; i < 9; i++) check_eq("s2_pc", 64'(dlv(i)), 64'(32'(4 * i)));

    // Redirect with two responses still in flight
    mem_hold = 1'b1;
    step(1'b0, '0);
    step(1'b1, 32'h0000_0101);
    mem_hold = 1'b0;
    check_eq("s4_fetch_valid", 64'(bus.fetch_data_valid), 64'd0);
    check_eq("s4_req_addr", 64'(bus.imem_req_addr), 64'h100);
    delivered.delete();
    repeat (8) step(1'b0, '0);
    check_eq("s4_first_pc", 64'(dlv(0)), 64'h100);
    check_eq("s4_second_pc", 64'(dlv(1)), 64'h104);

    // Decode stalled: the credit rule caps issue at the FIFO depth
    fready = 1'b0;
    do_reset();
    nreq = 0;
    repeat (10) step(1'b0, '0);
    check_eq("s3_nreq", 64'(nreq), 64'd4);
    fready = 1'b1;
    delivered.delete();
    repeat (8) step(1'b0, '0);
    for (int i = 0; i < 5; i++) check_eq("s3_drain_pc", 64'(dlv(i)), 64'(32'(4 * i)));

    // Issue stall mid-stream
    delivered.delete();
    repeat (5) step(1'b0, '0);
    en = 1'b0;
    repeat (5) step(1'b0, '0);
    en = 1'b1;
    repeat (8) step(1'b0, '0);
    check_eq("s5_count_min", 64'(delivered.size() >= 10), 64'd1);
    for (int i = 1; i < delivered.size(); i++)
      check_eq("s5_seq", 64'(delivered[i]), 64'(delivered[0] + 32'(4 * i)));

    // PC wrap-around
    step(1'b1, 32'hFFFF_FFFC);
    delivered.delete();
    repeat (8) step(1'b0, '0);
    check_eq("s6_wrap_first", 64'(dlv(0)), 64'hFFFF_FFFC);
    check_eq("s6_wrap_second", 64'(dlv(1)), 64'h0);

    // Randomized traffic with variable memory latency, redirects and resets
    rand_lat = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if (n % 1000 == 999) do_reset();
      en     = ($urandom_range(0, 9) != 0);
      fready = ($urandom_range(0, 3) != 0);
      rrdy   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 24) == 0) step(1'b1, $urandom);
      else step(1'b0, '0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
